// File: rtl/cga_pkg.sv
// Shared CGA definitions: VRAM arbiter access phases and the standard VRAM address widths.
package cga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A1   = 2'd1,
        ST_A2   = 2'd2,
        ST_A3   = 2'd3
    } vram_state_e;

    localparam int CGA_ADDR_WIDTH   = 14;
    localparam int TANDY_ADDR_WIDTH = 15;

endpackage

// File: rtl/cga_vram_arbiter.sv
// Single-ported VRAM arbiter: display fetch owns its sequencer slots, CPU accesses are
// queued and run as a fixed three-cycle access launched inside the isa_op_enable window.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int ADDR_WIDTH = CGA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  isa_op_enable,
    input  logic                  vram_read,
    input  logic                  vram_read_a0,
    input  logic [ADDR_WIDTH-2:0] disp_addr,
    input  logic                  isa_req,
    input  logic                  isa_we,
    input  logic [ADDR_WIDTH-1:0] isa_addr,
    input  logic [7:0]            isa_wdata,
    output logic [7:0]            isa_rdata,
    output logic                  isa_ack,
    output logic                  isa_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  ram_we_n,
    output logic                  collision
);

    vram_state_e           state_reg;
    vram_state_e           phase;
    logic                  pending_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            wdata_reg;
    logic [7:0]            rdata_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic                  ack_reg;
    logic                  collision_reg;

    logic                  capture;
    logic                  launch;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [7:0]            eff_wdata;

    // The launch cycle itself is phase A1, so state_reg steps straight from IDLE to A2;
    // a request captured in its launch cycle is forwarded from the ISA inputs.
    always_comb begin
        capture   = !reset && (state_reg == ST_IDLE) && !pending_reg && isa_req;
        launch    = !reset && (state_reg == ST_IDLE) && (pending_reg || capture) && isa_op_enable;
        eff_addr  = pending_reg ? addr_reg  : isa_addr;
        eff_wdata = pending_reg ? wdata_reg : isa_wdata;
        phase     = launch ? ST_A1 : state_reg;

        if (vram_read) begin
            ram_addr = {disp_addr, vram_read_a0};
        end else if (phase == ST_A1) begin
            ram_addr = eff_addr;
        end else if (phase != ST_IDLE) begin
            ram_addr = addr_reg;
        end else begin
            ram_addr = ram_addr_reg;
        end

        ram_wdata = (phase == ST_A1) ? eff_wdata : wdata_reg;
        ram_we_n  = !((state_reg == ST_A2) && we_reg && !vram_read);
        isa_busy  = pending_reg || (state_reg != ST_IDLE) || capture;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            ram_addr_reg  <= '0;
            ack_reg       <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            ram_addr_reg <= ram_addr;
            ack_reg      <= (state_reg == ST_A3);

            if (capture) begin
                pending_reg <= 1'b1;
                we_reg      <= isa_we;
                addr_reg    <= isa_addr;
                wdata_reg   <= isa_wdata;
            end

            case (state_reg)
                ST_IDLE: if (launch) state_reg <= ST_A2;
                ST_A2:   state_reg <= ST_A3;
                ST_A3: begin
                    state_reg   <= ST_IDLE;
                    pending_reg <= 1'b0;
                    if (!we_reg) rdata_reg <= ram_rdata;
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (vram_read && (phase != ST_IDLE)) collision_reg <= 1'b1;
        end
    end

    assign isa_rdata = rdata_reg;
    assign isa_ack   = ack_reg;
    assign collision = collision_reg;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a 32-slot CGA sequencer model and a VRAM model.
module tb_cga_vram_arbiter;

    localparam int AW = 14;

    logic          clk;
    logic          reset;
    logic          isa_op_enable;
    logic          vram_read;
    logic          vram_read_a0;
    logic [AW-2:0] disp_addr;
    logic          isa_req;
    logic          isa_we;
    logic [AW-1:0] isa_addr;
    logic [7:0]    isa_wdata;
    logic [7:0]    isa_rdata;
    logic          isa_ack;
    logic          isa_busy;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          ram_we_n;
    logic          collision;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    logic [4:0]    clkdiv;
    logic          seq_en;
    int            n_checks;
    int            n_fail;

    cga_vram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .isa_op_enable(isa_op_enable), .vram_read(vram_read),
        .vram_read_a0(vram_read_a0), .disp_addr(disp_addr), .isa_req(isa_req),
        .isa_we(isa_we), .isa_addr(isa_addr), .isa_wdata(isa_wdata), .isa_rdata(isa_rdata),
        .isa_ack(isa_ack), .isa_busy(isa_busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_we_n(ram_we_n), .collision(collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!ram_we_n) mem[ram_addr] <= ram_wdata;
    end

    // Enable windows 5-14 and 21-30, display slots 1-4 and 17-20.
    task automatic step();
        @(posedge clk);
        #1;
        isa_req       = 1'b0;
        clkdiv        = clkdiv + 5'd1;
        isa_op_enable = seq_en && ((clkdiv >= 5 && clkdiv <= 14) || (clkdiv >= 21 && clkdiv <= 30));
        vram_read     = seq_en && ((clkdiv >= 1 && clkdiv <= 4) || (clkdiv >= 17 && clkdiv <= 20));
        vram_read_a0  = clkdiv[0];
    endtask

    task automatic goto(input logic [4:0] n);
        for (int i = 0; i < 40 && clkdiv != n; i++) step();
        n_checks++;
        if (clkdiv !== n) begin n_fail++; $display("FAIL goto clkdiv=%0d want %0d", clkdiv, n); end
    endtask

    task automatic request(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        isa_req = 1'b1; isa_we = we; isa_addr = a; isa_wdata = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; seq_en = 1'b0;
        step(); step();
        preload(14'h3FFF, 8'h5A);
        preload(14'h0010, 8'h3C);
        preload(14'h0300, 8'hEE);
        preload(14'h0500, 8'hEE);
        #1;
        n_checks += 6;
        if (isa_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got %b want 0", isa_busy); end
        if (isa_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_ack got %b want 0", isa_ack); end
        if (isa_rdata !== 8'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 00", isa_rdata); end
        if (ram_we_n !== 1'b1)  begin n_fail++; $display("FAIL rst_we_n got %b want 1", ram_we_n); end
        if (ram_addr !== '0)    begin n_fail++; $display("FAIL rst_addr got %h want 0000", ram_addr); end
        if (collision !== 1'b0) begin n_fail++; $display("FAIL rst_collision got %b want 0", collision); end
        reset = 1'b0; seq_en = 1'b1; clkdiv = 5'd31;
        step();
        $display("reset done: busy=%b ack=%b we_n=%b", isa_busy, isa_ack, ram_we_n);
    endtask

    task automatic test_write();
        goto(5'd2);
        request(1'b1, 14'h0123, 8'hA5);
        #1;
        n_checks += 2;
        if (isa_busy !== 1'b1)   begin n_fail++; $display("FAIL w_busy_req got %b want 1", isa_busy); end
        if (ram_addr !== 14'h1578) begin n_fail++; $display("FAIL w_disp_addr got %h want 1578", ram_addr); end
        goto(5'd5); #1;
        n_checks += 2;
        if (ram_addr !== 14'h0123) begin n_fail++; $display("FAIL w_a1_addr got %h want 0123", ram_addr); end
        if (ram_we_n !== 1'b1)     begin n_fail++; $display("FAIL w_a1_we_n got %b want 1", ram_we_n); end
        step(); #1;
        n_checks += 3;
        if (ram_we_n !== 1'b0)     begin n_fail++; $display("FAIL w_a2_we_n got %b want 0", ram_we_n); end
        if (ram_addr !== 14'h0123) begin n_fail++; $display("FAIL w_a2_addr got %h want 0123", ram_addr); end
        if (ram_wdata !== 8'hA5)   begin n_fail++; $display("FAIL w_a2_wdata got %h want a5", ram_wdata); end
        step(); #1;
        n_checks += 2;
        if (ram_we_n !== 1'b1) begin n_fail++; $display("FAIL w_a3_we_n got %b want 1", ram_we_n); end
        if (isa_ack !== 1'b0)  begin n_fail++; $display("FAIL w_a3_ack got %b want 0", isa_ack); end
        step(); #1;
        n_checks += 2;
        if (isa_ack !== 1'b1)  begin n_fail++; $display("FAIL w_ack got %b want 1", isa_ack); end
        if (isa_busy !== 1'b0) begin n_fail++; $display("FAIL w_ack_busy got %b want 0", isa_busy); end
        step(); #1;
        n_checks += 2;
        if (isa_ack !== 1'b0)         begin n_fail++; $display("FAIL w_ack_pulse got %b want 0", isa_ack); end
        if (mem[14'h0123] !== 8'hA5)  begin n_fail++; $display("FAIL w_mem got %h want a5", mem[14'h0123]); end
        $display("write 0123<=a5: mem=%h", mem[14'h0123]);
    endtask

    task automatic test_read();
        goto(5'd20); #1;
        n_checks++;
        if (isa_busy !== 1'b0) begin n_fail++; $display("FAIL r_busy_before got %b want 0", isa_busy); end
        step();
        request(1'b0, 14'h3FFF, 8'h00);
        #1;
        n_checks += 2;
        if (isa_busy !== 1'b1)     begin n_fail++; $display("FAIL r_busy21 got %b want 1", isa_busy); end
        if (ram_addr !== 14'h3FFF) begin n_fail++; $display("FAIL r_a1_addr got %h want 3fff", ram_addr); end
        step(); #1;
        n_checks++;
        if (isa_busy !== 1'b1) begin n_fail++; $display("FAIL r_busy22 got %b want 1", isa_busy); end
        step(); #1;
        n_checks++;
        if (isa_busy !== 1'b1) begin n_fail++; $display("FAIL r_busy23 got %b want 1", isa_busy); end
        step(); #1;
        n_checks += 3;
        if (isa_ack !== 1'b1)    begin n_fail++; $display("FAIL r_ack24 got %b want 1", isa_ack); end
        if (isa_busy !== 1'b0)   begin n_fail++; $display("FAIL r_busy24 got %b want 0", isa_busy); end
        if (isa_rdata !== 8'h5A) begin n_fail++; $display("FAIL r_rdata got %h want 5a", isa_rdata); end
        step(); #1;
        n_checks += 2;
        if (isa_ack !== 1'b0)    begin n_fail++; $display("FAIL r_ack25 got %b want 0", isa_ack); end
        if (isa_rdata !== 8'h5A) begin n_fail++; $display("FAIL r_rdata_hold got %h want 5a", isa_rdata); end
        $display("read 3fff: rdata=%h", isa_rdata);
    endtask

    task automatic test_late();
        int ack_at;
        goto(5'd14);
        request(1'b0, 14'h0010, 8'h00);
        #1;
        n_checks++;
        if (ram_addr !== 14'h0010) begin n_fail++; $display("FAIL late_a1_addr got %h want 0010", ram_addr); end
        goto(5'd17); #1;
        n_checks += 2;
        if (isa_ack !== 1'b1)    begin n_fail++; $display("FAIL late_ack17 got %b want 1", isa_ack); end
        if (isa_rdata !== 8'h3C) begin n_fail++; $display("FAIL late_rdata got %h want 3c", isa_rdata); end
        step(); #1;
        n_checks++;
        if (collision !== 1'b0) begin n_fail++; $display("FAIL late_collision got %b want 0", collision); end
        goto(5'd15);
        request(1'b0, 14'h3FFF, 8'h00);
        ack_at = -1;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            step(); #1;
            if (isa_ack === 1'b1) ack_at = int'(clkdiv);
        end
        n_checks += 2;
        if (ack_at !== 24)       begin n_fail++; $display("FAIL late15_ack_at got %0d want 24", ack_at); end
        if (isa_rdata !== 8'h5A) begin n_fail++; $display("FAIL late15_rdata got %h want 5a", isa_rdata); end
        $display("late request at 15: ack at clkdiv %0d", ack_at);
    endtask

    task automatic test_back_to_back();
        goto(5'd5);
        request(1'b1, 14'h0200, 8'h11);
        step();
        request(1'b1, 14'h0300, 8'h22);
        #1;
        n_checks++;
        if (isa_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", isa_busy); end
        step(); step(); #1;
        n_checks++;
        if (isa_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack8 got %b want 1", isa_ack); end
        step();
        request(1'b1, 14'h0301, 8'h33);
        #1;
        n_checks++;
        if (ram_addr !== 14'h0301) begin n_fail++; $display("FAIL b2b_a1_addr got %h want 0301", ram_addr); end
        goto(5'd12); #1;
        n_checks++;
        if (isa_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack12 got %b want 1", isa_ack); end
        step(); #1;
        n_checks += 3;
        if (mem[14'h0200] !== 8'h11) begin n_fail++; $display("FAIL b2b_mem200 got %h want 11", mem[14'h0200]); end
        if (mem[14'h0300] !== 8'hEE) begin n_fail++; $display("FAIL b2b_mem300 got %h want ee", mem[14'h0300]); end
        if (mem[14'h0301] !== 8'h33) begin n_fail++; $display("FAIL b2b_mem301 got %h want 33", mem[14'h0301]); end
        $display("back-to-back: 0200=%h 0300=%h 0301=%h", mem[14'h0200], mem[14'h0300], mem[14'h0301]);
    endtask

    task automatic test_reset_mid();
        goto(5'd5);
        request(1'b1, 14'h0400, 8'h77);
        step(); #1;
        n_checks++;
        if (ram_we_n !== 1'b0) begin n_fail++; $display("FAIL rm_a2_we_n got %b want 0", ram_we_n); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks += 3;
        if (isa_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", isa_busy); end
        if (ram_we_n !== 1'b1) begin n_fail++; $display("FAIL rm_we_n got %b want 1", ram_we_n); end
        if (isa_ack !== 1'b0)  begin n_fail++; $display("FAIL rm_ack got %b want 0", isa_ack); end
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            n_checks++;
            if (isa_ack !== 1'b0 || isa_busy !== 1'b0)
                begin n_fail++; $display("FAIL rm_after%0d ack=%b busy=%b want 0 0", i, isa_ack, isa_busy); end
        end
        $display("reset mid-access: busy=%b ack=%b", isa_busy, isa_ack);
    endtask

    task automatic test_collision();
        goto(5'd5);
        request(1'b1, 14'h0500, 8'h99);
        step();
        vram_read = 1'b1; vram_read_a0 = 1'b1;
        #1;
        n_checks += 3;
        if (ram_addr !== 14'h1579) begin n_fail++; $display("FAIL col_addr got %h want 1579", ram_addr); end
        if (ram_we_n !== 1'b1)     begin n_fail++; $display("FAIL col_we_n got %b want 1", ram_we_n); end
        if (collision !== 1'b0)    begin n_fail++; $display("FAIL col_early got %b want 0", collision); end
        step(); #1;
        n_checks++;
        if (collision !== 1'b1) begin n_fail++; $display("FAIL col_set got %b want 1", collision); end
        step(); #1;
        n_checks++;
        if (isa_ack !== 1'b1) begin n_fail++; $display("FAIL col_ack got %b want 1", isa_ack); end
        goto(5'd18); #1;
        n_checks += 2;
        if (collision !== 1'b1)      begin n_fail++; $display("FAIL col_sticky got %b want 1", collision); end
        if (mem[14'h0500] !== 8'hEE) begin n_fail++; $display("FAIL col_mem got %h want ee", mem[14'h0500]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (collision !== 1'b0) begin n_fail++; $display("FAIL col_clear got %b want 0", collision); end
        $display("collision: cleared by reset, collision=%b", collision);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; seq_en = 1'b0; clkdiv = 5'd0;
        isa_op_enable = 1'b0; vram_read = 1'b0; vram_read_a0 = 1'b0;
        disp_addr = 13'h0ABC;
        isa_req = 1'b0; isa_we = 1'b0; isa_addr = '0; isa_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_write();
        test_read();
        test_late();
        test_back_to_back();
        test_reset_mid();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
